// File: rtl/prm_pkg.sv
// Shared constants and FSM state type for the PRM obstacle sweeper.
package prm_pkg;

  localparam int CODE_W_DEF    = 15;
  localparam int NUM_EDGES_DEF = 500;
  localparam int COUNT_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/prm_obstacle_sweeper_if.sv
// Obstacle stream, checker fan-out/fan-in and result handshake of the sweeper.
interface prm_obstacle_sweeper_if
  import prm_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int NUM_EDGES = NUM_EDGES_DEF
) ();

  logic                 obs_valid;
  logic [CODE_W-1:0]    obs_code;
  logic                 obs_last;
  logic                 obs_ready;
  logic [CODE_W-1:0]    chk_code;
  logic [NUM_EDGES-1:0] chk_mask;
  logic                 res_valid;
  logic [NUM_EDGES-1:0] res_blocked;
  logic [COUNT_W-1:0]   res_count;
  logic                 res_ready;

  // Producer, checker array and result consumer as seen from outside.
  modport master (
    output obs_valid, obs_code, obs_last, chk_mask, res_ready,
    input  obs_ready, chk_code, res_valid, res_blocked, res_count
  );

  modport slave (
    input  obs_valid, obs_code, obs_last, chk_mask, res_ready,
    output obs_ready, chk_code, res_valid, res_blocked, res_count
  );

endinterface

// File: rtl/prm_mask_accum.sv
// OR-accumulates checker masks over a frame and counts sampled obstacles.
module prm_mask_accum
  import prm_pkg::*;
#(
  parameter int NUM_EDGES = NUM_EDGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [NUM_EDGES-1:0] mask,
  output logic [NUM_EDGES-1:0] acc,
  output logic [COUNT_W-1:0]   count
);

  // NOTE: acc is a wide flop vector, not a memory, so it takes the async reset
  // like any other state; otherwise a mid-frame reset would leak old hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (enable) begin
      acc <= acc | mask;
      if (count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prm_obstacle_sweeper.sv
// Streams obstacle codes to the external edge checkers and ORs their masks per frame.
module prm_obstacle_sweeper
  import prm_pkg::*;
#(
  parameter int NUM_EDGES = NUM_EDGES_DEF,
  parameter int CODE_W    = CODE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prm_obstacle_sweeper_if.slave  bus
);

  sweep_state_t state;
  logic         sample;
  logic         xfer;
  logic         clear;

  assign bus.obs_ready = (state == S_IDLE) || (state == S_SWEEP);
  assign xfer          = bus.obs_valid && bus.obs_ready;
  assign clear         = xfer && (state == S_IDLE);

  // NOTE: all state uses non-blocking assignments so every flop sees the
  // pre-edge values of the others; blocking here would race within the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.chk_code  <= '0;
      sample        <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      // The checker mask for a code is valid one cycle after it is registered.
      sample <= xfer;
      if (xfer) bus.chk_code <= bus.obs_code;
      case (state)
        S_IDLE:  if (xfer) state <= bus.obs_last ? S_DRAIN : S_SWEEP;
        S_SWEEP: if (xfer && bus.obs_last) state <= S_DRAIN;
        S_DRAIN: begin
          state         <= S_DONE;
          bus.res_valid <= 1'b1;
        end
        S_DONE: if (bus.res_ready) begin
          state         <= S_IDLE;
          bus.res_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  prm_mask_accum #(.NUM_EDGES(NUM_EDGES)) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .enable (sample),
    .mask   (bus.chk_mask),
    .acc    (bus.res_blocked),
    .count  (bus.res_count)
  );

endmodule

// File: tb/tb_prm_obstacle_sweeper.sv
// Directed self-checking bench; the checker array is modelled as a code lookup.
module tb_prm_obstacle_sweeper;
  import prm_pkg::*;

  localparam int NE = NUM_EDGES_DEF;
  localparam int CW = CODE_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  prm_obstacle_sweeper_if #(.CODE_W(CW), .NUM_EDGES(NE)) bus ();

  prm_obstacle_sweeper #(.NUM_EDGES(NE), .CODE_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Edge checker model: a few special codes, otherwise edge (code mod NE).
  function automatic logic [NE-1:0] mask_of(input logic [CW-1:0] code);
    logic [NE-1:0] m;
    m = '0;
    case (code)
      15'h4A21: begin m[3] = 1'b1; m[17] = 1'b1; end
      15'h7005: begin m[0] = 1'b1; m[5] = 1'b1; end
      default:  m[int'(code) % NE] = 1'b1;
    endcase
    return m;
  endfunction

  always_comb bus.chk_mask = mask_of(bus.chk_code);

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic xfer(input logic [CW-1:0] code, input logic last);
    check("obs_ready_on_xfer", bus.obs_ready, 1);
    bus.obs_valid = 1'b1;
    bus.obs_code  = code;
    bus.obs_last  = last;
    @(negedge clk);
  endtask

  task automatic stop();
    bus.obs_valid = 1'b0;
    bus.obs_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.res_valid, 1);
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("release_valid", bus.res_valid, 0);
    check("release_ready", bus.obs_ready, 1);
  endtask

  logic [NE-1:0] exp_blk;

  initial begin
    bus.obs_valid = 1'b0;
    bus.obs_code  = '0;
    bus.obs_last  = 1'b0;
    bus.res_ready = 1'b0;

    // Reset values.
    #2;
    check("rst_valid", bus.res_valid, 0);
    check("rst_count", bus.res_count, 0);
    check("rst_blocked", bus.res_blocked, 0);
    check("rst_chk_code", bus.chk_code, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_rst", bus.obs_ready, 1);

    // Single obstacle frame: transfer, DRAIN, DONE.
    xfer(15'h4A21, 1'b1);
    stop();
    check("single_cyc2_valid", bus.res_valid, 0);
    check("single_cyc2_ready", bus.obs_ready, 0);
    check("single_chk_code", bus.chk_code, 15'h4A21);
    @(negedge clk);
    check("single_cyc3_valid", bus.res_valid, 1);
    exp_blk = '0; exp_blk[3] = 1'b1; exp_blk[17] = 1'b1;
    check("single_blocked", bus.res_blocked, exp_blk);
    check("single_count", bus.res_count, 1);
    release_result();

    // Back-to-back codes hitting {0}, {0,5}, {499}.
    xfer(15'd0, 1'b0);
    xfer(15'h7005, 1'b0);
    xfer(15'd499, 1'b1);
    stop();
    wait_done("b2b_done");
    exp_blk = '0; exp_blk[0] = 1'b1; exp_blk[5] = 1'b1; exp_blk[499] = 1'b1;
    check("b2b_blocked", bus.res_blocked, exp_blk);
    check("b2b_count", bus.res_count, 3);
    release_result();

    // Gaps between transfers hold chk_code and add nothing.
    xfer(15'd100, 1'b0);
    stop();
    check("gap1_code", bus.chk_code, 100);
    @(negedge clk);
    check("gap2_code", bus.chk_code, 100);
    check("gap_ready", bus.obs_ready, 1);
    xfer(15'd101, 1'b1);
    stop();
    wait_done("gap_done");
    exp_blk = '0; exp_blk[100] = 1'b1; exp_blk[101] = 1'b1;
    check("gap_blocked", bus.res_blocked, exp_blk);
    check("gap_count", bus.res_count, 2);

    // Hold DONE for 10 cycles with a pending obstacle that must not be taken.
    bus.obs_valid = 1'b1;
    bus.obs_code  = 15'd42;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_blocked", bus.res_blocked, exp_blk);
      check("hold_count", bus.res_count, 2);
      check("hold_ready", bus.obs_ready, 0);
    end
    check("hold_chk_code", bus.chk_code, 101);
    stop();
    release_result();
    xfer(15'd7, 1'b1);
    stop();
    wait_done("next_done");
    exp_blk = '0; exp_blk[7] = 1'b1;
    check("next_blocked", bus.res_blocked, exp_blk);
    check("next_count", bus.res_count, 1);
    release_result();

    // Reset mid-frame discards the partial result.
    for (int i = 0; i < 4; i++) xfer(CW'(300 + i), 1'b0);
    stop();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.res_valid, 0);
    check("midrst_count", bus.res_count, 0);
    check("midrst_blocked", bus.res_blocked, 0);
    check("midrst_chk_code", bus.chk_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", bus.obs_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        seen |= bus.res_valid;
      end
      check("midrst_no_valid", seen, 0);
    end
    exp_blk = '0;
    for (int i = 0; i < 8; i++) begin
      xfer(CW'(200 + i), i == 7);
      exp_blk[200 + i] = 1'b1;
    end
    stop();
    wait_done("post_rst_done");
    check("post_rst_blocked", bus.res_blocked, exp_blk);
    check("post_rst_count", bus.res_count, 8);
    release_result();

    // Count saturation over a 70000-obstacle frame.
    for (int i = 0; i < 70000; i++) begin
      bus.obs_valid = 1'b1;
      bus.obs_code  = CW'(i);
      bus.obs_last  = (i == 69999);
      @(negedge clk);
    end
    stop();
    wait_done("sat_done");
    check("sat_count", bus.res_count, 16'hFFFF);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
